// File: rtl/usrt_pkg.sv
// Shared types and helpers for the USRT datapath.
// Used by the receiver and the planned transmitter.
package usrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Parity bit a sender must append for the given data.
    function automatic logic parity_bit(
        input logic [15:0] d,
        input logic        odd
    );
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/usrt_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
// A pop frees the slot so a same-edge push may land when full.
module usrt_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = cnt;
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/usrt_rx_fifo_receiver.sv
// Parametrised USRT receiver: start-framed LSB-first words,
// optional parity, stop check, buffered with error flags.
module usrt_rx_fifo_receiver
    import usrt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              si,
    input  logic                              ien,
    input  logic                              rd_en,
    input  logic                              err_clr,
    output logic                              rd_valid,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_perr,
    output logic                              rd_ferr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              ovr,
    output logic                              irq
);

    localparam int CW = $clog2(DATA_W);
    localparam int FW = DATA_W + 2;

    rx_state_t         state;
    rx_state_t         nstate;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              perr_q;
    logic              last;
    logic              push;
    logic              full;
    logic              empty;
    logic              ovf;
    logic [FW-1:0]     wdata;
    logic [FW-1:0]     head;

    assign last = (cnt == CW'(DATA_W-1));

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (en && si != LINE_IDLE) nstate = DATA;
            end
            DATA: begin
                if (!en)
                    nstate = IDLE;
                else if (last)
                    nstate = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: nstate = en ? STOP : IDLE;
            STOP:   nstate = (si == LINE_IDLE) ? IDLE : BREAK;
            BREAK: begin
                if (si == LINE_IDLE) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            shreg  <= '0;
            perr_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt    <= '0;
                    perr_q <= 1'b0;
                end
                DATA: begin
                    shreg[cnt] <= si;
                    cnt        <= cnt + CW'(1);
                end
                PARITY: begin
                    perr_q <= si != parity_bit(16'(shreg), PARITY_ODD[0]);
                end
                default: ;
            endcase
        end
    end

    assign push  = (state == STOP);
    assign wdata = {shreg, perr_q, ~si};
    // A word is lost only when full and no pop makes room this edge.
    assign ovf   = push & full & ~(rd_en & ~empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr <= 1'b0;
        end else if (ovf) begin
            ovr <= 1'b1;
        end else if (err_clr) begin
            ovr <= 1'b0;
        end
    end

    usrt_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .wdata (wdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .head  (head)
    );

    assign rd_valid = ~empty;
    assign {rd_data, rd_perr, rd_ferr} = head;
    assign irq = ien & (rd_valid | ovr);

endmodule

// File: tb/tb_usrt_rx_fifo_receiver.sv
// Scoreboard bench for usrt_rx_fifo_receiver.
// Default parameters: 8 data bits, even parity, depth 4.
module tb_usrt_rx_fifo_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       si;
    logic       ien;
    logic       rd_en;
    logic       err_clr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_ferr;
    logic [2:0] fifo_count;
    logic       ovr;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;
    int q[$];
    bit exp_ovr = 1'b0;

    always #5 clk = ~clk;

    usrt_rx_fifo_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .si         (si),
        .ien        (ien),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_perr    (rd_perr),
        .rd_ferr    (rd_ferr),
        .fifo_count (fifo_count),
        .ovr        (ovr),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bitout(input logic b);
        si = b;
        tick();
    endtask

    task automatic check_head(input string tag);
        int e;
        e = (q.size() > 0) ? q.pop_front() : -1;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_word"}, 32'({rd_data, rd_perr, rd_ferr}), e);
    endtask

    task automatic read_one(input string tag);
        check_head(tag);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit pflip,
                        input bit stopb, input bit pop_stop);
        logic [9:0] w;
        w = {d, pflip, ~stopb};
        bitout(1'b0);
        for (int i = 0; i < 8; i++) bitout(d[i]);
        bitout((^d) ^ pflip);
        if (pop_stop) begin
            check_head("pop_at_stop");
            rd_en = 1'b1;
        end
        if (q.size() == 4 && !pop_stop)
            exp_ovr = 1'b1;
        else
            q.push_back(int'(w));
        bitout(stopb);
        rd_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_data"}, 32'(rd_data), 32'd0);
        check({tag, "_perr"}, 32'(rd_perr), 32'd0);
        check({tag, "_ferr"}, 32'(rd_ferr), 32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_ovr"}, 32'(ovr), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        si      = 1'b1;
        ien     = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        en    = 1'b1;
        repeat (2) tick();

        // Clean 0xA5, even parity
        send(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5_count", 32'(fifo_count), 32'd1);
        check("a5_irq", 32'(irq), 32'd1);
        read_one("a5");
        check("a5_empty", 32'(rd_valid), 32'd0);
        check("a5_irq_off", 32'(irq), 32'd0);

        // Parity error
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        check("perr_count", 32'(fifo_count), 32'd1);
        read_one("perr");
        check("perr_empty", 32'(rd_valid), 32'd0);
        check("perr_count0", 32'(fifo_count), 32'd0);

        // Framing error then held-low line
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (5) bitout(1'b0);
        check("brk_count", 32'(fifo_count), 32'd1);
        bitout(1'b1);
        bitout(1'b1);
        check("brk_count2", 32'(fifo_count), 32'd1);
        read_one("ferr");
        send(8'h01, 1'b0, 1'b1, 1'b0);
        read_one("after_brk");

        // Overrun
        for (int k = 1; k <= 5; k++) begin
            send(8'(k * 8'h11), 1'b0, 1'b1, 1'b0);
            bitout(1'b1);
        end
        check("ovr_count", 32'(fifo_count), 32'd4);
        check("ovr_set", 32'(ovr), 32'(exp_ovr));
        check("ovr_irq", 32'(irq), 32'd1);
        for (int k = 0; k < 4; k++) read_one("ovr_rd");
        check("ovr_empty", 32'(rd_valid), 32'd0);
        check("ovr_sticky", 32'(ovr), 32'd1);
        check("ovr_irq_hold", 32'(irq), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        check("ovr_clr", 32'(ovr), 32'(exp_ovr));
        check("ovr_irq_clr", 32'(irq), 32'd0);

        // Full with simultaneous pop and push
        for (int k = 1; k <= 4; k++) begin
            send(8'(k * 8'h11), 1'b0, 1'b1, 1'b0);
        end
        send(8'h55, 1'b0, 1'b1, 1'b1);
        check("pp_ovr", 32'(ovr), 32'(exp_ovr));
        check("pp_count", 32'(fifo_count), 32'd4);
        for (int k = 0; k < 4; k++) read_one("pp_rd");
        check("pp_empty", 32'(fifo_count), 32'd0);

        // Reset mid-frame with a word buffered
        send(8'h5A, 1'b0, 1'b1, 1'b0);
        bitout(1'b1);
        bitout(1'b0);
        for (int i = 0; i < 4; i++) bitout(1'b1);
        reset = 1'b1;
        #2;
        check_reset_outputs("midrst");
        q.delete();
        si = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("postrst");

        // Enable dropped mid-frame
        bitout(1'b0);
        bitout(1'b1);
        bitout(1'b0);
        bitout(1'b1);
        en = 1'b0;
        bitout(1'b1);
        en = 1'b1;
        repeat (12) bitout(1'b1);
        check("abort_count", 32'(fifo_count), 32'd0);
        check("abort_valid", 32'(rd_valid), 32'd0);

        send(8'h7E, 1'b0, 1'b1, 1'b0);
        read_one("clean7e");
        check("final_count", 32'(fifo_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usrt_rx_fifo_receiver.md
Name: usrt_rx_fifo_receiver

Overview:
Parametrised synchronous serial receiver for the USRT datapath and the successor to the fixed 8-bit receiver. It deserialises start-framed words of DATA_W bits, LSB first, on the shared bit clock. It optionally checks parity, always checks the stop bit, and buffers words with per-word error flags in a FIFO. A level interrupt and a valid/read handshake serve the host side.

Parameters:
DATA_W, 8, data bits per frame (5..16)
PARITY_EN, 1, 1 = parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
FIFO_DEPTH, 4, receive buffer entries, power of two, at least 2

Ports:
clk  in  1  bit clock; all flops on rising edge
reset  in  1  asynchronous, active-high; clears all state
en  in  1  receive enable; start bits are ignored while low
si  in  1  serial input; idle high
ien  in  1  interrupt enable
rd_en  in  1  pop the FIFO head; ignored when empty
err_clr  in  1  clears the sticky overrun flag
rd_valid  out  1  FIFO not empty
rd_data  out  DATA_W  FIFO head data
rd_perr  out  1  parity error flag of the head word (0 if PARITY_EN=0)
rd_ferr  out  1  framing error flag of the head word
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of occupied entries
ovr  out  1  sticky overrun flag
irq  out  1  interrupt: ien & (rd_valid | ovr)

Behaviour:
- Reset: state IDLE, shift register 0, FIFO empty, ovr=0. Output values in reset: rd_valid=0, rd_data=0, rd_perr=0, rd_ferr=0, fifo_count=0, irq=0.
- FSM states: IDLE, DATA, PARITY, STOP, BREAK.
- IDLE: when en=1 and si=0 on a clock edge, that edge counts as the start bit. Go to DATA with bit counter = 0.
- DATA: each edge shifts si into bit[cnt], LSB first. After bit DATA_W-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: sample si. perr = (XOR of data bits ^ si) != PARITY_ODD.
- STOP: sample si. ferr = ~si. Push {data, perr, ferr} to the FIFO on this edge. Next state is IDLE if si=1, or BREAK if si=0.
- BREAK: hold until si=1, then go to IDLE. This stops a held-low line from restarting frames.
- en low while in DATA or PARITY: the frame aborts, the FSM returns to IDLE on the next edge, and nothing is pushed.
- Latency: the word is visible (rd_valid=1, rd_data valid) on the edge after the stop-bit sample edge. Total time from start-bit edge to visibility is 1 + DATA_W + PARITY_EN + 1 edges.
- Reads: rd_data, rd_perr and rd_ferr are registered head outputs (FWFT). rd_en while rd_valid=1 pops the head, and the next entry is presented on the following cycle.
- Full FIFO with a push and no pop: the word is dropped, ovr is set, and the stored entries are unchanged.
- Full FIFO with a push and a pop on the same edge: both happen, count stays at FIFO_DEPTH, ovr is unchanged.
- Empty FIFO with a push and rd_en on the same edge: rd_en is ignored and the push lands.
- err_clr clears ovr. If err_clr and a new overrun happen on the same edge, ovr stays set (set wins).
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH and never underflows.
- irq is combinational from registered signals and is glitch-free.

Decomposition:
- Package usrt_pkg holds:
  - the rx_state_t enum {IDLE, DATA, PARITY, STOP, BREAK};
  - the idle line level constant;
  - a function computing the expected parity bit from data and PARITY_ODD.
- Sub-module usrt_sync_fifo, parameterised on width (DATA_W+2) and depth. It provides push, pop, full, empty, count and FWFT head. The same FIFO is reused by the planned transmitter.
- The FSM, shifter and flag logic stay in the top module.

Test Plan:
- DATA_W=8, even parity, data 0xA5: si = start 0, data bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> rd_valid=1 one edge after stop; rd_data=0xA5, rd_perr=0, rd_ferr=0; irq=1 with ien=1.
- Same frame with parity bit 1 -> rd_data=0xA5, rd_perr=1; rd_en pop -> rd_valid=0, fifo_count=0.
- Data 0x3C with stop bit 0, then si held low for 5 cycles, then high -> one entry with rd_ferr=1; no second frame while low (BREAK); next frame 0x01 received correctly.
- Depth 4: send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads -> fifo_count=4, ovr=1, pops return 0x11..0x44; err_clr -> ovr=0.
- FIFO full, pulse rd_en on the same edge as the 5th stop bit -> ovr=0, fifo_count=4, head sequence 0x22, 0x33, 0x44, 0x55.
- Assert reset after data bit 3 of a frame, then release; also drop en mid-frame on a separate frame -> all outputs return to reset values, no push; the next clean frame 0x7E is received with no error flags.
